alu_tx_hex_formatter: RTL
=========================

// Module: alu_tx_hex_formatter
// PURPOSE
//  Converts an ALU result to an ASCII hex string and writes it byte-by-byte into the UART TX FIFO.
//  Sits between the ALU and the TX FIFO and replaces the single-digit '+48' converter.
//  Emits a result of any width as NDIG = ceil(DATA_W/4) hex characters, MSB nibble first.
//  Honours fifo_full backpressure and can optionally append a CR/LF terminator.
// PARAMETERS
//  DATA_W          8   ALU result width; NDIG = (DATA_W+3)/4; the top nibble is zero-padded.
//  OUT_W           8   FIFO data width (ASCII byte); must be 8.
//  SUPPRESS_ZEROS  0   1 = skip leading '0' digits; a value of 0 still emits a single '0'.
// PORTS
//  CLK        in   1        clock, rising edge
//  RESET      in   1        asynchronous, active-high reset
//  enviar     in   1        send request; sampled only in IDLE
//  DATO_ALU   in   DATA_W   value to format; captured on the accepting edge
//  fifo_full  in   1        TX FIFO full; no write is issued while high
//  WR_FIFO    out  1        FIFO write strobe; one byte per high cycle
//  data_fifo  out  OUT_W    ASCII byte; valid while WR_FIFO=1, otherwise 8'h00
//  busy       out  1        high from the cycle after accept until the return to IDLE
//  drop       out  1        one-cycle pulse when enviar=1 while busy; the request is discarded
// BEHAVIOUR
//  Reset (async): state=IDLE, value=0, digit index=0; WR_FIFO=0, data_fifo=0, busy=0, drop=0.
//  States: IDLE, EMIT, TERM_CR, TERM_LF. Output encoding is in the package.
//  IDLE: if enviar=1, capture DATO_ALU and load idx.
//    idx = NDIG-1, or the highest non-zero nibble when SUPPRESS_ZEROS=1 (0 if all nibbles are zero).
//    Then go to EMIT. Otherwise stay in IDLE.
//  EMIT: WR_FIFO = !fifo_full; data_fifo = ascii(nibble[idx]).
//    ascii(n) = 8'h30+n for n<10, else 8'h41+(n-10), uppercase.
//    On a write with idx>0: idx decrements.
//    On a write with idx=0: go to TERM_CR if TERMINATOR_CRLF_EN, else IDLE.
//    If fifo_full=1: hold state, idx and value; no write that cycle.
//  TERM_CR: write 8'h0D when !fifo_full, then go to TERM_LF. TERM_LF: write 8'h0A, then go to IDLE.
//  WR_FIFO and data_fifo are combinational from state, idx, value and fifo_full.
//    The FIFO commits the byte on the same rising edge.
//  Latency: accept on edge N; the first byte can be written in cycle N+1.
//    With no backpressure, NDIG (+2) consecutive writes follow.
//  In IDLE, WR_FIFO=0 and data_fifo=0; no latched outputs.
//  enviar while busy (any non-IDLE state): ignored, drop=1 for that cycle. DATO_ALU is not re-sampled.
//  enviar on the same cycle the FSM returns to IDLE: not accepted, and no drop.
//    It is treated as busy; the request must be re-issued.
//  fifo_full toggling every cycle: exactly one write per cycle with fifo_full=0; no byte is skipped or duplicated.
//  Reset mid-string: abort immediately. The partial string stays in the FIFO and no further bytes are written.
// CONFIGURATION
//  TERMINATOR_CRLF_EN defined: each string is followed by 8'h0D then 8'h0A; same backpressure rules apply.
//  Not defined: TERM_CR/TERM_LF are not compiled in, and EMIT returns directly to IDLE after the last digit.
// STRUCTURE
//  Package tx_fmt_pkg:
//    state encoding localparams (ST_IDLE, ST_EMIT, ST_TERM_CR, ST_TERM_LF);
//    ASCII_0=8'h30, ASCII_A=8'h41, ASCII_CR=8'h0D, ASCII_LF=8'h0A;
//    a function computing NDIG from DATA_W.
//  Sub-module nibble_to_ascii: combinational 4-bit -> 8-bit ASCII. Instantiated once on the selected nibble.
//  Leading-nibble priority encoder lives inline in this module.
// TESTING
//  1 DATA_W=8, CRLF_EN, DATO_ALU=8'h3C, enviar 1 cycle, fifo_full=0
//    -> writes 33,43,0D,0A on 4 consecutive cycles starting N+1; busy low after the last.
//  2 DATA_W=16, SUPPRESS_ZEROS=1, 16'h00A5 -> writes 41,35 only. 16'h0000 -> writes 30 only.
//  3 DATA_W=12, 12'hF07, fifo_full high for 3 cycles after the first byte
//    -> 46 written, then a 3-cycle stall with WR_FIFO=0, then 30,37; no duplicates.
//  4 enviar pulsed again 2 cycles after accept -> drop=1 for 1 cycle; only the first string appears in the FIFO.
//  5 RESET asserted after the 2nd byte of 16'h1234 -> FIFO holds 31,32 only; outputs 0 immediately; IDLE.
//  6 CRLF_EN undefined, 8'h09 -> writes 30,39, then IDLE; no 0D/0A ever seen.

Source files
------------

// File: rtl/alu_tx_hex_formatter_pkg.sv
// Shared types and constants for the ALU-to-UART hex string formatter.
// Provides state encoding, ASCII constants and the digit-count helper.
package tx_fmt_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_EMIT    = 2'd1;
    localparam logic [1:0] ST_TERM_CR = 2'd2;
    localparam logic [1:0] ST_TERM_LF = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = ST_IDLE,
        EMIT    = ST_EMIT,
        TERM_CR = ST_TERM_CR,
        TERM_LF = ST_TERM_LF
    } state_t;

    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_A  = 8'h41;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    function automatic int ndig(input int w);
        return (w + 3) / 4;
    endfunction

endpackage

// File: rtl/alu_tx_hex_formatter_if.sv
// Handshake/bus bundle between the ALU side, the formatter and the TX FIFO.
// Signals: enviar, DATO_ALU, fifo_full (to formatter); WR_FIFO, data_fifo, busy, drop (from it).
interface alu_tx_hex_formatter_if #(
    parameter int DATA_W = 8,
    parameter int OUT_W  = 8
);
    logic              enviar;
    logic [DATA_W-1:0] DATO_ALU;
    logic              fifo_full;
    logic              WR_FIFO;
    logic [OUT_W-1:0]  data_fifo;
    logic              busy;
    logic              drop;

    modport master (
        output enviar, DATO_ALU, fifo_full,
        input  WR_FIFO, data_fifo, busy, drop
    );

    modport slave (
        input  enviar, DATO_ALU, fifo_full,
        output WR_FIFO, data_fifo, busy, drop
    );
endinterface

// File: rtl/alu_tx_hex_formatter_nibble_to_ascii.sv
// Combinational 4-bit nibble to uppercase ASCII hex character.
// Ports: nib_i (nibble in), ascii_o (ASCII byte out).
module nibble_to_ascii
    import tx_fmt_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [7:0] ascii_o
);
    always_comb begin
        if (nib_i < 4'd10) begin
            ascii_o = ASCII_0 + {4'h0, nib_i};
        end else begin
            ascii_o = ASCII_A + {4'h0, nib_i} - 8'd10;
        end
    end
endmodule

// File: rtl/alu_tx_hex_formatter.sv
// Formats an ALU result as MSB-first ASCII hex and writes it into the UART TX FIFO.
// Ports: CLK, RESET (async, active-high), bus (slave modport: enviar, DATO_ALU,
// fifo_full in; WR_FIFO, data_fifo, busy, drop out). Macro TERMINATOR_CRLF_EN adds CR/LF.
module alu_tx_hex_formatter
    import tx_fmt_pkg::*;
#(
    parameter int DATA_W         = 8,
    parameter int OUT_W          = 8,
    parameter bit SUPPRESS_ZEROS = 1'b0
) (
    input logic                   CLK,
    input logic                   RESET,
    alu_tx_hex_formatter_if.slave bus
);
    localparam int NDIG  = ndig(DATA_W);
    localparam int PAD_W = NDIG * 4;
    localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;

    state_t             state_q, state_d;
    logic [PAD_W-1:0]   val_q, val_d;
    logic [IDX_W-1:0]   idx_q, idx_d;

    logic [PAD_W-1:0]   din_pad;
    logic [IDX_W-1:0]   lead_idx;
    logic [3:0]         sel_nib;
    logic [7:0]         sel_ascii;
    logic               wr;
    logic [OUT_W-1:0]   data;
    logic               drop;

    // Top nibble is zero-padded when DATA_W is not a multiple of 4.
    assign din_pad = PAD_W'(bus.DATO_ALU);
    assign sel_nib = val_q[{idx_q, 2'b00} +: 4];

    // Highest non-zero nibble; ascending scan so the last hit wins.
    always_comb begin
        lead_idx = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (din_pad[4*i +: 4] != 4'h0) begin
                lead_idx = IDX_W'(i);
            end
        end
    end

    nibble_to_ascii u_n2a (
        .nib_i   (sel_nib),
        .ascii_o (sel_ascii)
    );

    always_comb begin
        state_d = state_q;
        val_d   = val_q;
        idx_d   = idx_q;
        wr      = 1'b0;
        data    = '0;
        unique case (state_q)
            IDLE: begin
                if (bus.enviar) begin
                    val_d   = din_pad;
                    idx_d   = SUPPRESS_ZEROS ? lead_idx : IDX_W'(NDIG - 1);
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (!bus.fifo_full) begin
                    wr   = 1'b1;
                    data = sel_ascii;
                    if (idx_q != '0) begin
                        idx_d = idx_q - 1'b1;
                    end else begin
`ifdef TERMINATOR_CRLF_EN
                        state_d = TERM_CR;
`else
                        state_d = IDLE;
`endif
                    end
                end
            end
`ifdef TERMINATOR_CRLF_EN
            TERM_CR: begin
                if (!bus.fifo_full) begin
                    wr      = 1'b1;
                    data    = ASCII_CR;
                    state_d = TERM_LF;
                end
            end
            TERM_LF: begin
                if (!bus.fifo_full) begin
                    wr      = 1'b1;
                    data    = ASCII_LF;
                    state_d = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
        // A request on the final-write cycle is lost silently, not dropped.
        drop = bus.enviar && (state_q != IDLE) && (state_d != IDLE);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= IDLE;
            val_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            val_q   <= val_d;
            idx_q   <= idx_d;
        end
    end

    assign bus.WR_FIFO   = wr;
    assign bus.data_fifo = data;
    assign bus.busy      = (state_q != IDLE);
    assign bus.drop      = drop;

endmodule
